// File: rtl/spi_regfile_target_pkg.sv
// Shared types and frame constants for the SPI register-file target.
package spi_regfile_target_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWdata,
    StRdata
  } state_e;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned CMD_RW_BIT = 7;

endpackage

// File: rtl/spi_regfile_target_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall detection on the synced level.
module spi_regfile_target_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_target.sv
// SPI target with a register file: runtime CPOL/CPHA, burst auto-increment writes and reads.
module spi_regfile_target
  import spi_regfile_target_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 16,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       spi_cs_n,
  input  logic                       spi_sclk,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic                       spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic                       busy_o
);

  localparam int unsigned       CntW     = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0]   LastCmd  = CntW'(CMD_W - 1);
  localparam logic [CntW-1:0]   LastData = CntW'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_next;
  logic                tx_load_q, tx_load_d;
  logic                wr_pulse_q, wr_valid;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                mosi_meta_q, mosi_s_q;
  logic                cpol_q, cpha_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_data, frame;
  logic                we;

  logic cs_n_s, cs_rise, cs_fall, sclk_s, sclk_rise, sclk_fall;
  logic sclk_edge, leading, trailing, sample_edge, launch_edge, abort;

  // cs_n sync resets low so a transfer already in flight at reset never looks like a new select.
  spi_regfile_target_sync_edge #(.ResetVal(1'b0)) u_cs_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_regfile_target_sync_edge #(.ResetVal(1'b0)) u_sclk_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (spi_sclk),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign sclk_edge   = sclk_rise | sclk_fall;
  assign leading     = sclk_edge & (sclk_s != cpol_q);
  assign trailing    = sclk_edge & (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trailing : leading;
  assign launch_edge = cpha_q ? leading : trailing;
  assign abort       = cs_rise | ~ena;

  assign frame     = {rx_q, mosi_s_q};
  assign rd_data   = (32'(addr_q) < NUM_REGS) ? regs_q[addr_q] : '0;
  assign addr_next = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + ADDR_W'(1);
  assign wr_valid  = we && (32'(addr_q) < NUM_REGS);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    tx_load_d = 1'b0;
    we        = 1'b0;
    if (tx_load_q) tx_d = rd_data;
    if (abort) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      tx_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
          end
        end
        StCmd: begin
          if (sample_edge) begin
            rx_d      = frame[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == LastCmd) begin
              bit_cnt_d = '0;
              addr_d    = frame[ADDR_W-1:0];
              if (frame[CMD_RW_BIT]) begin
                state_d = StWdata;
              end else begin
                state_d   = StRdata;
                tx_load_d = 1'b1;
              end
            end
          end
        end
        StWdata: begin
          if (sample_edge) begin
            rx_d      = frame[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == LastData) begin
              bit_cnt_d = '0;
              we        = 1'b1;
              addr_d    = addr_next;
            end
          end
        end
        StRdata: begin
          if (sample_edge) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == LastData) begin
              bit_cnt_d = '0;
              addr_d    = addr_next;
              tx_load_d = 1'b1;
            end
          // The launch edge at a frame boundary keeps the freshly loaded MSB on the line.
          end else if (launch_edge && bit_cnt_q != '0) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      tx_load_q   <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      tx_load_q   <= tx_load_d;
      wr_pulse_q  <= wr_valid;
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
      if (wr_valid) wr_addr_q <= addr_q;
      if (cs_n_s) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (wr_valid) begin
      regs_q[addr_q] <= frame;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign busy_o      = (state_q != StIdle);
  assign spi_miso_oe = ena && (state_q != StIdle);
  assign spi_miso    = spi_miso_oe && (state_q == StRdata) && tx_q[DATA_W-1];
  assign wr_pulse_o  = wr_pulse_q;
  assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile_target.sv
// Randomised bench for spi_regfile_target, checked against an array model of the register file.
module tb_spi_regfile_target;

  localparam int unsigned NR = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n, ena, cpol, cpha, cs_n, sclk, mosi;
  logic miso, oe, wr_pulse, busy;
  logic [NR*DW-1:0] regs;
  logic [AW-1:0] wr_addr;

  logic [DW-1:0] model [NR];
  int n_checks = 0;
  int n_pass = 0;
  int pulse_cnt = 0;

  spi_regfile_target #(
    .NUM_REGS  (NR),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RESET_VAL ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .cpol        (cpol),
    .cpha        (cpha),
    .spi_cs_n    (cs_n),
    .spi_sclk    (sclk),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (oe),
    .regs_o      (regs),
    .wr_pulse_o  (wr_pulse),
    .wr_addr_o   (wr_addr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_pulse) pulse_cnt++;

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = model[k];
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    wait_clk(6);
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  // Controller side: shifts n bits MSB first and returns what it sampled on miso.
  task automatic spi_bits(input logic [31:0] dout, input int n, output logic [31:0] din);
    din = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = dout[i];
        wait_clk(4);
        din[i] = miso;
        sclk = ~cpol;
        wait_clk(4);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = dout[i];
        wait_clk(4);
        din[i] = miso;
        sclk = cpol;
        wait_clk(4);
      end
    end
  endtask

  task automatic spi_end();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic do_write(input logic p, input logic h, input int a, input int nf,
                          input logic [31:0] data);
    logic [31:0] d;
    logic [7:0] fr;
    spi_begin(p, h);
    spi_bits(32'h80 | 32'(a), 8, d);
    for (int i = 0; i < nf; i++) begin
      fr = data[8*(nf-1-i) +: 8];
      spi_bits({24'h0, fr}, 8, d);
      model[(a + i) % NR] = fr;
    end
    spi_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = '0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(1);
    n_checks++; if (regs !== model_vec()) $display("FAIL reset_regs: got %h expected %h", regs, model_vec()); else n_pass++;
    n_checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else n_pass++;
    n_checks++; if (oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (wr_pulse !== 1'b0) $display("FAIL reset_pulse: got %b expected 0", wr_pulse); else n_pass++;
    n_checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); else n_pass++;
  endtask

  task automatic test_write_mode0();
    int base = pulse_cnt;
    do_write(1'b0, 1'b0, 3, 1, 32'hA5);
    n_checks++; if (regs[3*DW +: DW] !== 8'hA5) $display("FAIL w0_reg3: got %h expected a5", regs[3*DW +: DW]); else n_pass++;
    n_checks++; if (pulse_cnt - base != 1) $display("FAIL w0_pulses: got %0d expected 1", pulse_cnt - base); else n_pass++;
    n_checks++; if (wr_addr !== 4'd3) $display("FAIL w0_wr_addr: got %0d expected 3", wr_addr); else n_pass++;
    n_checks++; if (regs !== model_vec()) $display("FAIL w0_regs: got %h expected %h", regs, model_vec()); else n_pass++;
  endtask

  task automatic test_burst_mode3();
    int base = pulse_cnt;
    do_write(1'b1, 1'b1, 15, 2, 32'h1122);
    n_checks++; if (regs[15*DW +: DW] !== 8'h11) $display("FAIL b3_reg15: got %h expected 11", regs[15*DW +: DW]); else n_pass++;
    n_checks++; if (regs[0 +: DW] !== 8'h22) $display("FAIL b3_reg0: got %h expected 22", regs[0 +: DW]); else n_pass++;
    n_checks++; if (pulse_cnt - base != 2) $display("FAIL b3_pulses: got %0d expected 2", pulse_cnt - base); else n_pass++;
    n_checks++; if (regs !== model_vec()) $display("FAIL b3_regs: got %h expected %h", regs, model_vec()); else n_pass++;
  endtask

  task automatic test_read_modes();
    logic [31:0] d;
    for (int m = 1; m <= 2; m++) begin
      spi_begin(m[1], m[0]);
      spi_bits(32'h03, 8, d);
      n_checks++; if (oe !== 1'b1) $display("FAIL rd_oe_sel mode%0d: got %b expected 1", m, oe); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL rd_busy mode%0d: got %b expected 1", m, busy); else n_pass++;
      spi_bits(32'h0, 8, d);
      n_checks++; if (d[7:0] !== model[3]) $display("FAIL rd_data mode%0d: got %h expected %h", m, d[7:0], model[3]); else n_pass++;
      spi_end();
      n_checks++; if (oe !== 1'b0) $display("FAIL rd_oe_desel mode%0d: got %b expected 0", m, oe); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int base = pulse_cnt;
    spi_begin(1'b0, 1'b0);
    spi_bits(32'h82, 8, d);
    spi_bits(32'h16, 5, d);
    cs_n = 1'b1;
    wait_clk(3);
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
    wait_clk(8);
    n_checks++; if (regs[2*DW +: DW] !== model[2]) $display("FAIL abort_reg2: got %h expected %h", regs[2*DW +: DW], model[2]); else n_pass++;
    n_checks++; if (pulse_cnt != base) $display("FAIL abort_pulses: got %0d expected 0", pulse_cnt - base); else n_pass++;
  endtask

  task automatic test_ena();
    logic [31:0] d;
    int base = pulse_cnt;
    ena = 1'b0;
    spi_begin(1'b0, 1'b0);
    n_checks++; if (oe !== 1'b0) $display("FAIL ena_oe: got %b expected 0", oe); else n_pass++;
    spi_bits(32'h85, 8, d);
    spi_bits($urandom_range(0, 255), 8, d);
    spi_end();
    ena = 1'b1;
    wait_clk(2);
    n_checks++; if (regs !== model_vec()) $display("FAIL ena_regs: got %h expected %h", regs, model_vec()); else n_pass++;
    n_checks++; if (pulse_cnt != base) $display("FAIL ena_pulses: got %0d expected 0", pulse_cnt - base); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d, data;
    int mode, a, nf, base;
    for (int it = 0; it < 6; it++) begin
      mode = $urandom_range(0, 3);
      a    = $urandom_range(0, NR - 1);
      nf   = $urandom_range(1, 3);
      data = $urandom;
      base = pulse_cnt;
      do_write(mode[1], mode[0], a, nf, data);
      n_checks++; if (regs !== model_vec()) $display("FAIL rnd_regs it%0d: got %h expected %h", it, regs, model_vec()); else n_pass++;
      n_checks++; if (pulse_cnt - base != nf) $display("FAIL rnd_pulses it%0d: got %0d expected %0d", it, pulse_cnt - base, nf); else n_pass++;
      mode = $urandom_range(0, 3);
      a    = $urandom_range(0, NR - 1);
      nf   = $urandom_range(1, 3);
      spi_begin(mode[1], mode[0]);
      spi_bits(32'(a), 8, d);
      for (int i = 0; i < nf; i++) begin
        spi_bits(32'h0, 8, d);
        n_checks++;
        if (d[7:0] !== model[(a + i) % NR])
          $display("FAIL rnd_read it%0d addr %0d: got %h expected %h", it, (a + i) % NR, d[7:0], model[(a + i) % NR]);
        else n_pass++;
      end
      spi_end();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int base;
    spi_begin(1'b0, 1'b0);
    spi_bits(32'h86, 8, d);
    spi_bits($urandom_range(1, 255), 8, d);
    spi_bits(32'h5, 3, d);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    for (int k = 0; k < NR; k++) model[k] = '0;
    spi_bits(32'h1b, 5, d);
    spi_end();
    base = pulse_cnt;
    do_write(1'b0, 1'b0, 1, 1, 32'h5A);
    n_checks++; if (regs[1*DW +: DW] !== 8'h5A) $display("FAIL rstmid_reg1: got %h expected 5a", regs[1*DW +: DW]); else n_pass++;
    n_checks++; if (regs !== model_vec()) $display("FAIL rstmid_regs: got %h expected %h", regs, model_vec()); else n_pass++;
    n_checks++; if (pulse_cnt - base != 1) $display("FAIL rstmid_pulses: got %0d expected 1", pulse_cnt - base); else n_pass++;
    n_checks++; if (wr_addr !== 4'd1) $display("FAIL rstmid_wr_addr: got %0d expected 1", wr_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_mode0();
    test_burst_mode3();
    test_read_modes();
    test_abort();
    test_ena();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
